// File: rtl/bit_serial_pkg.sv
// Shared encodings and PRBS7 constants for the bit-serial link.
// Imported by the transmitter, its LFSR and receive-side blocks.
package bit_serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    // Fibonacci step for x^7 + x^6 + 1; output bit is s[6].
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// 7-bit Fibonacci PRBS7 generator with advance enable.
// Shared by the transmitter idle filler and the receive-side checker.
module prbs7_lfsr
    import bit_serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic bit_out
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = prbs7_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_out = lfsr_q[6];

endmodule

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter with valid/ready input and gapless frames.
// Define PRBS_IDLE_EN to fill idle time with PRBS7 instead of IDLE_LEVEL.
module bit_serializer_tx
    import bit_serial_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             w_out,
    output logic             busy,
    output logic             frame_start
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             fs_q;
    logic             fs_d;
    logic             accept;
    logic             head_bit;
    logic             idle_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fs_q    <= fs_d;
        end
    end

    assign accept   = valid_in && ready_out;
    assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        fs_d    = accept;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = data_in;
                    cnt_d   = CNT_LAST;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    // Reload on the last bit keeps frames back-to-back.
                    if (accept) begin
                        shift_d = data_in;
                        cnt_d   = CNT_LAST;
                    end else begin
                        state_d = ST_IDLE;
                        shift_d = '0;
                    end
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                end
            end
        endcase
    end

    always_comb begin
        ready_out   = (state_q == ST_IDLE) || (cnt_q == '0);
        busy        = (state_q == ST_SHIFT);
        w_out       = busy ? head_bit : idle_bit;
        frame_start = fs_q;
    end

`ifdef PRBS_IDLE_EN
    prbs7_lfsr u_prbs (
        .clk     (clk),
        .rst     (rst),
        .advance (state_q == ST_IDLE),
        .bit_out (idle_bit)
    );
`else
    assign idle_bit = IDLE_LEVEL;
`endif

endmodule
